lcd_text_scroller: RTL and testbench

- Upstream feeder for the character-LCD driver. Produces the two 128-bit, 16-character line images that the driver consumes on its i_line1/i_line2 inputs.
- Holds a message of up to 32 ASCII characters and scrolls a 16-character window of it across line 1, wrapping around the message.
- Line 2 is a static 16-character field written by the host.
- Window images are rebuilt serially and committed atomically, so the driver never samples a half-updated line.

---
 rtl/lcd_scroll_pkg.sv | 27 ++
 rtl/lcd_scroll_msg_ram.sv | 36 +++
 rtl/lcd_text_scroller.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_text_scroller.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_scroll_pkg.sv
// Shared definitions for the LCD text scroller.
// Holds the FSM state encoding, the blank character, the host write
// address map and the number of characters on one LCD line.
package lcd_scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } scroll_state_t;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    // Host address map: message characters, then the 16 line-2 characters
    localparam logic [5:0] MSG_BASE = 6'd0;
    localparam logic [5:0] L2_BASE  = 6'd32;
    localparam logic [5:0] L2_LAST  = 6'd47;

    localparam int LINE_CHARS = 16;

    // A full line of blanks, char 0 in the top byte
    function automatic logic [127:0] blank_line();
        return {LINE_CHARS{BLANK_CHAR}};
    endfunction

endpackage

// File: rtl/lcd_scroll_msg_ram.sv
// Message store for the LCD text scroller.
// DEPTH x 8 memory, synchronous write, asynchronous read.
// Ports:
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write character
//   raddr - read address (the scroller's read pointer)
//   rdata - character at raddr
// Contents are not reset; the host must load the message before use.
module lcd_scroll_msg_ram
    import lcd_scroll_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [DEPTH];

    // Host character writes
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lcd_text_scroller.sv
// Feeds the character-LCD driver with two 16-character line images.
// Line 1 is a 16-character window scrolling over a message of up to
// MSG_DEPTH characters (wrapping); line 2 is a static host-written field.
// The window is rebuilt one character per cycle into a shadow register and
// committed in one edge, so the driver never sees a partial line.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   wr_en/addr/data   - host character writes (0..31 message, 32..47 line 2)
//   i_len, i_start    - message length (latched on start), start pulse
//   i_stop            - return to idle (wins over i_start)
//   i_dir             - 0 scroll left, 1 scroll right
//   i_pause           - freeze the step timer
//   o_line1, o_line2  - line images, char 0 in [127:120]
//   o_frame           - one-cycle pulse when o_line1 changes
//   o_busy            - scroller is not idle
module lcd_text_scroller
    import lcd_scroll_pkg::*;
#(
    parameter int MSG_DEPTH  = 32,
    parameter int STEP_DIV   = 5000000,
    parameter int HOLD_STEPS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [5:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic [5:0]   i_len,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_dir,
    input  logic         i_pause,
    output logic [127:0] o_line1,
    output logic [127:0] o_line2,
    output logic         o_frame,
    output logic         o_busy
);

    localparam int AW    = $clog2(MSG_DEPTH);
    localparam int LW    = AW + 1;
    localparam int HMAX  = (HOLD_STEPS > 0) ? HOLD_STEPS : 1;
    localparam int CNT_W = $clog2(STEP_DIV * HMAX);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(STEP_DIV * HMAX - 1);

    scroll_state_t    state_r, state_nx_s;
    logic [LW-1:0]    len_r, len_in_s;
    logic [AW-1:0]    offset_r, off_next_s, p_r;
    logic [3:0]       idx_r;
    logic [CNT_W-1:0] cnt_r;
    logic [127:0]     shadow_r, line1_r, line2_r;
    logic             frame_r, adv_s;
    logic [7:0]       rdata_s;
    logic             msg_we_s, line2_we_s;

    // Step forward through the message, wrapping at len
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v,
                                               input logic [LW-1:0] n);
        logic [LW-1:0] v1;
        v1 = {1'b0, v} + LW'(1);
        if (v1 >= n) return '0;
        else         return v1[AW-1:0];
    endfunction

    // Step backward through the message, wrapping 0 -> len-1
    function automatic logic [AW-1:0] wrap_dec(input logic [AW-1:0] v,
                                               input logic [LW-1:0] n);
        if (v == '0) return AW'(n - LW'(1));
        else         return v - AW'(1);
    endfunction

    assign msg_we_s   = wr_en && (wr_addr < L2_BASE);
    assign line2_we_s = wr_en && (wr_addr >= L2_BASE) && (wr_addr <= L2_LAST);
    assign off_next_s = i_dir ? wrap_dec(offset_r, len_r) : wrap_inc(offset_r, len_r);

    lcd_scroll_msg_ram #(.DEPTH(MSG_DEPTH), .AW(AW)) u_msg_ram (
        .clk   (clk),
        .we    (msg_we_s),
        .waddr (wr_addr[AW-1:0]),
        .wdata (wr_data),
        .raddr (p_r),
        .rdata (rdata_s)
    );

    // Clamp the requested length to the message capacity
    always_comb begin
        len_in_s = LW'(i_len);
        if ({1'b0, i_len} > 7'(MSG_DEPTH)) begin
            len_in_s = LW'(MSG_DEPTH);
        end else begin
            len_in_s = LW'(i_len);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= ST_IDLE;
        else      state_r <= state_nx_s;
    end

    // Next state and the step-advance strobe
    always_comb begin
        state_nx_s = state_r;
        adv_s      = 1'b0;
        if (i_stop) begin
            state_nx_s = ST_IDLE;
        end else if (i_start) begin
            if (len_in_s == '0) state_nx_s = ST_IDLE;
            else                state_nx_s = ST_BUILD;
        end else begin
            case (state_r)
                ST_IDLE: state_nx_s = ST_IDLE;
                ST_BUILD: begin
                    if (idx_r == 4'd15) begin
                        if ((offset_r == '0) && (HOLD_STEPS > 0)) state_nx_s = ST_HOLD;
                        else                                      state_nx_s = ST_WAIT;
                    end else begin
                        state_nx_s = ST_BUILD;
                    end
                end
                ST_WAIT: begin
                    if (!i_pause && (cnt_r == WAIT_LAST)) begin
                        adv_s      = 1'b1;
                        state_nx_s = ST_BUILD;
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_HOLD: begin
                    if (!i_pause && (cnt_r == HOLD_LAST)) begin
                        adv_s      = 1'b1;
                        state_nx_s = ST_BUILD;
                    end else begin
                        state_nx_s = ST_HOLD;
                    end
                end
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // Datapath: window build, step timer, offset and line images
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r    <= '0;
            offset_r <= '0;
            p_r      <= '0;
            idx_r    <= 4'd0;
            cnt_r    <= '0;
            shadow_r <= blank_line();
            line1_r  <= blank_line();
            line2_r  <= blank_line();
            frame_r  <= 1'b0;
        end else begin
            frame_r <= 1'b0;
            if (line2_we_s) begin
                // addresses 32..47 map to chars 0..15 via the low nibble
                line2_r[{~wr_addr[3:0], 3'b000} +: 8] <= wr_data;
            end
            if (i_stop) begin
                idx_r <= 4'd0;
                cnt_r <= '0;
            end else if (i_start) begin
                len_r    <= len_in_s;
                offset_r <= '0;
                p_r      <= '0;
                idx_r    <= 4'd0;
                cnt_r    <= '0;
                if (len_in_s == '0) begin
                    line1_r <= blank_line();
                end
            end else begin
                case (state_r)
                    ST_BUILD: begin
                        shadow_r[{~idx_r, 3'b000} +: 8] <= rdata_s;
                        p_r   <= wrap_inc(p_r, len_r);
                        idx_r <= idx_r + 4'd1;
                        if (idx_r == 4'd15) begin
                            // last char goes straight into the committed image
                            line1_r <= {shadow_r[127:8], rdata_s};
                            frame_r <= 1'b1;
                            cnt_r   <= '0;
                        end
                    end
                    ST_WAIT, ST_HOLD: begin
                        if (!i_pause) begin
                            if (adv_s) begin
                                offset_r <= off_next_s;
                                p_r      <= off_next_s;
                                idx_r    <= 4'd0;
                                cnt_r    <= '0;
                            end else begin
                                cnt_r <= cnt_r + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        idx_r <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign o_line1 = line1_r;
    assign o_line2 = line2_r;
    assign o_frame = frame_r;
    assign o_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_lcd_text_scroller.sv
// Self-checking bench for lcd_text_scroller (STEP_DIV=4, HOLD_STEPS=2).
// Expected frame times and window images come from a model of the
// scrolling rules: image(off)[i] = msg[(off+i) mod len], frames 16 cycles
// after start and (interval + 16) cycles apart.
module tb_lcd_text_scroller;

    localparam int TB_STEP = 4;
    localparam int TB_HOLD = 2;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [5:0]   wr_addr;
    logic [7:0]   wr_data;
    logic [5:0]   i_len;
    logic         i_start;
    logic         i_stop;
    logic         i_dir;
    logic         i_pause;
    logic [127:0] o_line1;
    logic [127:0] o_line2;
    logic         o_frame;
    logic         o_busy;

    lcd_text_scroller #(.MSG_DEPTH(32), .STEP_DIV(TB_STEP), .HOLD_STEPS(TB_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .i_len   (i_len),
        .i_start (i_start),
        .i_stop  (i_stop),
        .i_dir   (i_dir),
        .i_pause (i_pause),
        .o_line1 (o_line1),
        .o_line2 (o_line2),
        .o_frame (o_frame),
        .o_busy  (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [7:0]   msg_m [0:31];
    logic [127:0] line2_m;
    logic [127:0] last_img_m;
    int           len_m;
    int           off_m;
    int           dir_m;
    int           next_exp;

    localparam logic [127:0] BLANK = {16{8'h20}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] img(input int off);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = msg_m[(off + i) % len_m];
        return r;
    endfunction

    function automatic int gap(input int off);
        return ((off == 0) ? TB_HOLD * TB_STEP : TB_STEP) + 16;
    endfunction

    function automatic int nxt(input int off);
        return (dir_m != 0) ? (off + len_m - 1) % len_m : (off + 1) % len_m;
    endfunction

    task automatic write_char(input int addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 6'(addr); wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic start_run(input int len_in, input int dir);
        @(negedge clk);
        i_len = 6'(len_in); i_dir = 1'(dir); i_start = 1'b1; i_stop = 1'b0;
        @(negedge clk);
        i_start = 1'b0;
        len_m    = (len_in > 32) ? 32 : len_in;
        dir_m    = dir;
        off_m    = 0;
        next_exp = cyc + 16;
    endtask

    task automatic stop_run();
        @(negedge clk);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
    endtask

    task automatic wait_frame(output int fc);
        fc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_frame === 1'b1) begin
                fc = cyc;
                break;
            end
        end
    endtask

    task automatic run_frames(input int n, input string tag);
        int fc;
        for (int k = 0; k < n; k++) begin
            wait_frame(fc);
            chk({tag, " frame time"}, 128'(fc), 128'(next_exp));
            last_img_m = img(off_m);
            chk({tag, " image"}, o_line1, last_img_m);
            next_exp = next_exp + gap(off_m);
            off_m    = nxt(off_m);
        end
    endtask

    initial begin
        int seen;
        int len_in;
        logic [7:0] hello [0:4];
        hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;
        wr_en = 1'b0; wr_addr = 6'd0; wr_data = 8'h00; i_len = 6'd0;
        i_start = 1'b0; i_stop = 1'b0; i_dir = 1'b0; i_pause = 1'b0;
        line2_m = BLANK;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("reset line1", o_line1, BLANK);
        chk("reset line2", o_line2, BLANK);
        chk("reset frame", 128'(o_frame), 128'(0));
        chk("reset busy", 128'(o_busy), 128'(0));
        @(negedge clk);
        rst = 1'b1;

        // left scroll over "HELLO", through a full wrap and the hold at offset 0
        for (int i = 0; i < 5; i++) begin
            msg_m[i] = hello[i];
            write_char(i, hello[i]);
        end
        chk("line2 untouched by msg writes", o_line2, line2_m);
        start_run(5, 0);
        chk("busy after start", 128'(o_busy), 128'(1));
        run_frames(7, "left");

        // pause inside the wait interval: no frame, image frozen, timer resumes
        @(negedge clk);
        i_pause = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (o_frame === 1'b1) seen++;
        end
        i_pause = 1'b0;
        chk("pause no frame", 128'(seen), 128'(0));
        chk("pause image held", o_line1, last_img_m);
        next_exp = next_exp + 50;
        run_frames(2, "resume");

        // start while running restarts from offset 0
        start_run(5, 0);
        run_frames(1, "restart");

        // simultaneous start and stop: stop wins
        @(negedge clk);
        i_start = 1'b1; i_stop = 1'b1; i_len = 6'd5;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
        chk("start+stop idle", 128'(o_busy), 128'(0));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_frame === 1'b1) seen++;
        end
        chk("idle no frame", 128'(seen), 128'(0));
        chk("idle image retained", o_line1, last_img_m);

        // right scroll with hold after offset 0
        start_run(5, 1);
        run_frames(3, "right");
        stop_run();
        chk("stop busy", 128'(o_busy), 128'(0));
        chk("stop image retained", o_line1, last_img_m);

        // length 40 clamps to 32; right step from 0 must land on 31
        for (int i = 0; i < 32; i++) begin
            msg_m[i] = 8'($urandom_range(33, 126));
            write_char(i, msg_m[i]);
        end
        start_run(40, 1);
        run_frames(3, "clamp");
        stop_run();

        // zero length: idle with a blank line 1
        start_run(0, 0);
        chk("len0 busy", 128'(o_busy), 128'(0));
        chk("len0 line1", o_line1, BLANK);

        // randomized messages, lengths and directions
        for (int it = 0; it < 3; it++) begin
            len_in = $urandom_range(1, 45);
            for (int i = 0; i < ((len_in > 32) ? 32 : len_in); i++) begin
                msg_m[i] = 8'($urandom_range(33, 126));
                write_char(i, msg_m[i]);
            end
            start_run(len_in, int'($urandom_range(0, 1)));
            run_frames(4, "random");
            stop_run();
        end

        // line 2 writes, including ignored addresses
        write_char(32, 8'h41);
        line2_m[127:120] = 8'h41;
        chk("line2 char0", 128'(o_line2[127:120]), 128'(8'h41));
        write_char(47, 8'h5A);
        line2_m[7:0] = 8'h5A;
        chk("line2 char15", 128'(o_line2[7:0]), 128'(8'h5A));
        write_char(40, 8'h6D);
        line2_m[127-8*8 -: 8] = 8'h6D;
        write_char(50, 8'h51);
        chk("line2 full", o_line2, line2_m);

        // asynchronous reset in the middle of a build pass
        start_run(5, 0);
        repeat (5) @(negedge clk);
        chk("mid-build busy", 128'(o_busy), 128'(1));
        rst = 1'b0;
        #1;
        chk("async rst line1", o_line1, BLANK);
        chk("async rst line2", o_line2, BLANK);
        chk("async rst frame", 128'(o_frame), 128'(0));
        chk("async rst busy", 128'(o_busy), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle after rst", 128'(o_busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
